line_stepper: RTL and testbench
===============================

Name: line_stepper

Overview:
- Converts one line segment (types::line_t) into an ordered stream of pixel coordinates using integer Bresenham stepping. It is the write-side counterpart to the per-pixel edge test.
- It feeds the frame-buffer/overlay writer with one (x,y) pixel per accepted handshake.
- Line input uses valid/ready; pixel output uses valid/ready with a last flag.
- It sits between the line list / vertex transform stage and the pixel writer.

Parameters:
- LINE_BITS, default types::LINE_BITS, coordinate width per axis. The line_t fields are x0,y0,x1,y1, packed MSB to LSB.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- line_i  in  4*LINE_BITS  types::line_t {x0,y0,x1,y1}, unsigned coordinates
- line_valid_i  in  1  line_i is valid
- line_ready_o  out  1  block is idle and can accept a line
- pix_x_o  out  LINE_BITS  current pixel x
- pix_y_o  out  LINE_BITS  current pixel y
- pix_valid_o  out  1  pix_x_o/pix_y_o are valid
- pix_last_o  out  1  current pixel is the endpoint (x1,y1)
- pix_ready_i  in  1  downstream accepts the pixel
- busy_o  out  1  a line is in progress

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - line_ready_o=1 after release; it is 0 while rst_i is high.
  - pix_valid_o=0, pix_last_o=0, busy_o=0, pix_x_o=0, pix_y_o=0.
  - All internal registers are cleared.
- States: IDLE, RUN.
- IDLE:
  - line_ready_o=1, pix_valid_o=0.
  - When line_valid_i=1, the line is accepted on that clock edge and the block goes to RUN.
  - On acceptance the block registers:
    - cur=(x0,y0), end=(x1,y1)
    - dx=|x1-x0|, dy=-|y1-y0|
    - sx=+1 if x1>=x0, else -1; sy=+1 if y1>=y0, else -1
    - err=dx+dy
- Latency: the first pixel is valid in the cycle after acceptance. Points are never reordered; the stream always starts at (x0,y0).
- RUN:
  - line_ready_o=0, busy_o=1, pix_valid_o=1.
  - pix_x_o/pix_y_o show cur. pix_last_o=1 exactly when cur==end.
- Beat on pix_valid_o && pix_ready_i:
  - If pix_last_o=1, go to IDLE; line_ready_o rises in the next cycle.
  - Otherwise compute e2=2*err from the old err. Both conditions below use the same e2 and their updates to err are summed in one cycle:
    - if e2>=dy: err+=dy and x+=sx
    - if e2<=dx: err+=dx and y+=sy
- Backpressure: while pix_ready_i=0, cur, err, pix_last_o and all outputs hold stable. pix_valid_o never drops mid-line.
- Beat count per line is exactly max(dx,|dy|)+1.
- A degenerate line (x0==x1, y0==y1) produces one beat with pix_last_o=1.
- Arithmetic widths:
  - dx and |dy| are LINE_BITS unsigned.
  - err is a signed LINE_BITS+2 register; e2 is signed LINE_BITS+3.
  - No overflow is permitted for any coordinate pair.
  - cur never leaves [0, 2^LINE_BITS-1] because stepping ends at end.
- Back-to-back lines: no acceptance in the same cycle as the last beat, so there is a minimum 1 idle cycle between lines.
- line_valid_i is ignored during RUN.
- Reset mid-line immediately drops pix_valid_o. The line is discarded and is not resumed.

Test Plan (LINE_BITS=6):
- Horizontal line (2,5)->(6,5), pix_ready_i=1:
  - Beats x=2,3,4,5,6 with y=5.
  - pix_last_o only on x=6.
  - line_ready_o=1 two cycles after the last beat edge at the latest.
- Diagonal (0,0)->(3,3): exactly 4 beats (0,0),(1,1),(2,2),(3,3); last on (3,3).
- Reversed steep line (4,7)->(3,2):
  - Exactly (4,7),(4,6),(4,5),(3,4),(3,3),(3,2), 6 beats.
  - Last on (3,2).
- Single point (9,9)->(9,9): one beat with pix_last_o=1, then IDLE. Full width (0,0)->(63,0): 64 beats with no wrap.
- Backpressure: in the (2,5)->(6,5) line, hold pix_ready_i=0 for 3 cycles while showing (4,5). Outputs stay at (4,5), valid=1, last=0. Stepping resumes to (5,5) after pix_ready_i returns to 1.
- Reset on the third beat of (0,0)->(3,3):
  - pix_valid_o=0 asynchronously.
  - After release line_ready_o=1.
  - A new line (1,1)->(2,1) streams (1,1),(2,1) cleanly.

Source files
------------

// File: rtl/line_stepper.sv
// Bresenham line rasteriser: accepts one line segment and streams its pixels
// from (x0,y0) to (x1,y1), one pixel per accepted valid/ready beat.
package types;
  localparam int LINE_BITS = 6;
  typedef struct packed {
    logic [LINE_BITS-1:0] x0;
    logic [LINE_BITS-1:0] y0;
    logic [LINE_BITS-1:0] x1;
    logic [LINE_BITS-1:0] y1;
  } line_t;
endpackage

// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid never depends on ready, and once raised it holds (with
// stable data) until that transfer. busy_o mirrors the RUN state of the FSM.
module line_stepper #(
  parameter int LINE_BITS = types::LINE_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [4*LINE_BITS-1:0] line_i,
  input  logic                   line_valid_i,
  output logic                   line_ready_o,
  output logic [LINE_BITS-1:0]   pix_x_o,
  output logic [LINE_BITS-1:0]   pix_y_o,
  output logic                   pix_valid_o,
  output logic                   pix_last_o,
  input  logic                   pix_ready_i,
  output logic                   busy_o
);
  localparam int EW = LINE_BITS + 2;
  localparam logic [LINE_BITS-1:0] ONE = LINE_BITS'(1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                r_state;
  logic [LINE_BITS-1:0]  r_cur_x, r_cur_y, r_end_x, r_end_y;
  logic [LINE_BITS-1:0]  r_dx, r_dy_mag;
  logic                  r_sx_neg, r_sy_neg;
  logic signed [EW-1:0]  r_err;
  logic                  r_last;

  logic [LINE_BITS-1:0]  w_x0, w_y0, w_x1, w_y1;
  logic [LINE_BITS-1:0]  w_dx, w_dy_mag;
  logic [EW-1:0]         w_err_init;
  logic                  w_last_init;

  assign {w_x0, w_y0, w_x1, w_y1} = line_i;
  assign w_dx        = (w_x1 >= w_x0) ? (w_x1 - w_x0) : (w_x0 - w_x1);
  assign w_dy_mag    = (w_y1 >= w_y0) ? (w_y1 - w_y0) : (w_y0 - w_y1);
  assign w_err_init  = {2'b00, w_dx} - {2'b00, w_dy_mag};
  assign w_last_init = (w_x0 == w_x1) && (w_y0 == w_y1);

  // Step decision: both tests use e2 = 2*err taken from the old err.
  logic signed [EW:0]    w_e2, w_dx_e, w_dymag_e, w_dy_e, w_err_ext;
  logic signed [EW:0]    w_add_x, w_add_y, w_err_next;
  logic                  w_step_x, w_step_y;
  logic [LINE_BITS-1:0]  w_nx, w_ny;
  logic                  w_last_next;

  assign w_e2       = {r_err, 1'b0};
  assign w_dx_e     = {3'b000, r_dx};
  assign w_dymag_e  = {3'b000, r_dy_mag};
  assign w_dy_e     = -w_dymag_e;
  assign w_err_ext  = {r_err[EW-1], r_err};
  assign w_step_x   = (w_e2 >= w_dy_e);
  assign w_step_y   = (w_e2 <= w_dx_e);
  assign w_add_x    = w_step_x ? w_dy_e : '0;
  assign w_add_y    = w_step_y ? w_dx_e : '0;
  assign w_err_next = w_err_ext + w_add_x + w_add_y;

  assign w_nx = !w_step_x ? r_cur_x : (r_sx_neg ? r_cur_x - ONE : r_cur_x + ONE);
  assign w_ny = !w_step_y ? r_cur_y : (r_sy_neg ? r_cur_y - ONE : r_cur_y + ONE);
  assign w_last_next = (w_nx == r_end_x) && (w_ny == r_end_y);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
      r_end_x  <= '0;
      r_end_y  <= '0;
      r_dx     <= '0;
      r_dy_mag <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_err    <= '0;
      r_last   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (line_valid_i) begin
            r_state  <= ST_RUN;
            r_cur_x  <= w_x0;
            r_cur_y  <= w_y0;
            r_end_x  <= w_x1;
            r_end_y  <= w_y1;
            r_dx     <= w_dx;
            r_dy_mag <= w_dy_mag;
            r_sx_neg <= (w_x1 < w_x0);
            r_sy_neg <= (w_y1 < w_y0);
            r_err    <= w_err_init;
            r_last   <= w_last_init;
          end
        end
        ST_RUN: begin
          if (pix_ready_i) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_last  <= 1'b0;
            end else begin
              r_cur_x <= w_nx;
              r_cur_y <= w_ny;
              r_err   <= w_err_next[EW-1:0];
              r_last  <= w_last_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign line_ready_o = (r_state == ST_IDLE) && !rst_i;
  assign pix_valid_o  = (r_state == ST_RUN);
  assign busy_o       = (r_state == ST_RUN);
  assign pix_last_o   = r_last;
  assign pix_x_o      = r_cur_x;
  assign pix_y_o      = r_cur_y;
endmodule

// File: tb/tb_line_stepper.sv
// Bench for line_stepper: expected pixels are queued when a line is driven and
// popped as the DUT delivers beats.
module tb_line_stepper;
  localparam int LB = 6;
  localparam int W  = 2*LB + 1;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [4*LB-1:0] line_i;
  logic            line_valid_i;
  logic            line_ready_o;
  logic [LB-1:0]   pix_x_o, pix_y_o;
  logic            pix_valid_o, pix_last_o;
  logic            pix_ready_i;
  logic            busy_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  line_stepper #(.LINE_BITS(LB)) dut (
    .clk_i(clk), .rst_i(rst_i), .line_i(line_i), .line_valid_i(line_valid_i),
    .line_ready_o(line_ready_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
    .pix_valid_o(pix_valid_o), .pix_last_o(pix_last_o),
    .pix_ready_i(pix_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int x, input int y, input bit last);
    exp_q.push_back({x[LB-1:0], y[LB-1:0], last});
  endtask

  // Reference Bresenham used only for random lines.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 >= x0) ? x1 - x0 : x0 - x1;
    dy = (y1 >= y0) ? y0 - y1 : y1 - y0;
    sx = (x1 >= x0) ? 1 : -1;
    sy = (y1 >= y0) ? 1 : -1;
    err = dx + dy; x = x0; y = y0;
    for (int n = 0; n < 200; n++) begin
      push_exp(x, y, (x == x1) && (y == y1));
      if ((x == x1) && (y == y1)) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Waits for line_ready_o (bounded) and presents one line for one edge.
  task automatic drive_line(input int x0, input int y0, input int x1, input int y1,
                            output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (line_ready_o) begin ok = 1'b1; break; end
    end
    line_i       = {x0[LB-1:0], y0[LB-1:0], x1[LB-1:0], y1[LB-1:0]};
    line_valid_i = ok;
    @(posedge clk); #1;
    line_valid_i = 1'b0;
  endtask

  // Returns the next pixel beat (bounded); ready is randomised per cycle.
  task automatic collect_beat(input int ready_pct, output logic [LB-1:0] gx,
                              output logic [LB-1:0] gy, output logic gl, output bit ok);
    ok = 1'b0; gx = '0; gy = '0; gl = 1'b0;
    for (int c = 0; c < 60; c++) begin
      pix_ready_i = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (pix_valid_o && pix_ready_i) begin
        gx = pix_x_o; gy = pix_y_o; gl = pix_last_o; ok = 1'b1;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    pix_ready_i = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1; line_valid_i = 1'b0; line_i = '0; pix_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (line_ready_o !== 1'b0 || pix_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: ready=%0b valid=%0b, want 0 0", line_ready_o, pix_valid_o);
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({line_ready_o, pix_valid_o, pix_last_o, busy_o, pix_x_o, pix_y_o} !== {4'b1000, 12'd0}) begin
      miscompares++;
      $display("FAIL reset_release: ready=%0b valid=%0b last=%0b busy=%0b x=%0d y=%0d, want 1 0 0 0 0 0",
               line_ready_o, pix_valid_o, pix_last_o, busy_o, pix_x_o, pix_y_o);
    end
  endtask

  task automatic test_horizontal();
    logic [LB-1:0] gx, gy; logic gl; bit ok; logic [W-1:0] e;
    for (int x = 2; x <= 6; x++) push_exp(x, 5, x == 6);
    drive_line(2, 5, 6, 5, ok);
    while (exp_q.size() > 0) begin
      collect_beat(100, gx, gy, gl, ok);
      e = exp_q.pop_front(); vectors++;
      if (!ok || {gx, gy, gl} !== e) begin
        miscompares++;
        $display("FAIL horizontal_beat: got (%0d,%0d) last=%0b seen=%0b, want (%0d,%0d) last=%0b",
                 gx, gy, gl, ok, e[W-1-:LB], e[LB:1], e[0]);
      end
    end
    @(negedge clk); vectors++;
    if (line_ready_o !== 1'b1 || pix_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL horizontal_idle: ready=%0b valid=%0b, want 1 0", line_ready_o, pix_valid_o);
    end
  endtask

  task automatic test_diagonal_ignore_valid();
    logic [LB-1:0] gx, gy; logic gl; bit ok; logic [W-1:0] e;
    for (int i = 0; i <= 3; i++) push_exp(i, i, i == 3);
    drive_line(0, 0, 3, 3, ok);
    line_i = {6'd40, 6'd41, 6'd42, 6'd43};
    line_valid_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (n == 2) line_valid_i = 1'b0;
      collect_beat(100, gx, gy, gl, ok);
      e = exp_q.pop_front(); vectors++;
      if (!ok || {gx, gy, gl} !== e) begin
        miscompares++;
        $display("FAIL diagonal_beat: got (%0d,%0d) last=%0b seen=%0b, want (%0d,%0d) last=%0b",
                 gx, gy, gl, ok, e[W-1-:LB], e[LB:1], e[0]);
      end
    end
    @(negedge clk); vectors++;
    if (pix_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL diagonal_extra_beat: valid=%0b busy=%0b, want 0 0", pix_valid_o, busy_o);
    end
  endtask

  task automatic test_steep_reversed();
    logic [LB-1:0] gx, gy; logic gl; bit ok; logic [W-1:0] e;
    push_exp(4, 7, 0); push_exp(4, 6, 0); push_exp(4, 5, 0);
    push_exp(3, 4, 0); push_exp(3, 3, 0); push_exp(3, 2, 1);
    drive_line(4, 7, 3, 2, ok);
    while (exp_q.size() > 0) begin
      collect_beat(100, gx, gy, gl, ok);
      e = exp_q.pop_front(); vectors++;
      if (!ok || {gx, gy, gl} !== e) begin
        miscompares++;
        $display("FAIL steep_beat: got (%0d,%0d) last=%0b seen=%0b, want (%0d,%0d) last=%0b",
                 gx, gy, gl, ok, e[W-1-:LB], e[LB:1], e[0]);
      end
    end
  endtask

  task automatic test_point_and_full_width();
    logic [LB-1:0] gx, gy; logic gl; bit ok; logic [W-1:0] e;
    push_exp(9, 9, 1);
    drive_line(9, 9, 9, 9, ok);
    collect_beat(100, gx, gy, gl, ok);
    e = exp_q.pop_front(); vectors++;
    if (!ok || {gx, gy, gl} !== e) begin
      miscompares++;
      $display("FAIL point_beat: got (%0d,%0d) last=%0b seen=%0b, want (9,9) last=1", gx, gy, gl, ok);
    end
    @(negedge clk); vectors++;
    if (line_ready_o !== 1'b1 || pix_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL point_idle: ready=%0b valid=%0b, want 1 0", line_ready_o, pix_valid_o);
    end
    for (int x = 0; x <= 63; x++) push_exp(x, 0, x == 63);
    drive_line(0, 0, 63, 0, ok);
    while (exp_q.size() > 0) begin
      collect_beat(100, gx, gy, gl, ok);
      e = exp_q.pop_front(); vectors++;
      if (!ok || {gx, gy, gl} !== e) begin
        miscompares++;
        $display("FAIL full_width_beat: got (%0d,%0d) last=%0b seen=%0b, want (%0d,%0d) last=%0b",
                 gx, gy, gl, ok, e[W-1-:LB], e[LB:1], e[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [LB-1:0] gx, gy; logic gl; bit ok; logic [W-1:0] e;
    for (int x = 2; x <= 6; x++) push_exp(x, 5, x == 6);
    drive_line(2, 5, 6, 5, ok);
    for (int n = 0; n < 5; n++) begin
      if (n == 2) begin
        pix_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk); vectors++;
          if ({pix_x_o, pix_y_o, pix_valid_o, pix_last_o} !== {6'd4, 6'd5, 2'b10}) begin
            miscompares++;
            $display("FAIL backpressure_hold: got (%0d,%0d) valid=%0b last=%0b, want (4,5) 1 0",
                     pix_x_o, pix_y_o, pix_valid_o, pix_last_o);
          end
          @(posedge clk); #1;
        end
      end
      collect_beat(100, gx, gy, gl, ok);
      e = exp_q.pop_front(); vectors++;
      if (!ok || {gx, gy, gl} !== e) begin
        miscompares++;
        $display("FAIL backpressure_beat: got (%0d,%0d) last=%0b seen=%0b, want (%0d,%0d) last=%0b",
                 gx, gy, gl, ok, e[W-1-:LB], e[LB:1], e[0]);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [LB-1:0] gx, gy; logic gl; bit ok; logic [W-1:0] e;
    drive_line(0, 0, 3, 3, ok);
    collect_beat(100, gx, gy, gl, ok);
    collect_beat(100, gx, gy, gl, ok);
    rst_i = 1'b1;
    #1; vectors++;
    if (pix_valid_o !== 1'b0 || line_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midline_drop: valid=%0b ready=%0b, want 0 0", pix_valid_o, line_ready_o);
    end
    @(negedge clk); rst_i = 1'b0;
    @(posedge clk); #1; vectors++;
    if (line_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midline_release: ready=%0b busy=%0b, want 1 0", line_ready_o, busy_o);
    end
    exp_q.delete();
    push_exp(1, 1, 0); push_exp(2, 1, 1);
    drive_line(1, 1, 2, 1, ok);
    while (exp_q.size() > 0) begin
      collect_beat(100, gx, gy, gl, ok);
      e = exp_q.pop_front(); vectors++;
      if (!ok || {gx, gy, gl} !== e) begin
        miscompares++;
        $display("FAIL post_reset_beat: got (%0d,%0d) last=%0b seen=%0b, want (%0d,%0d) last=%0b",
                 gx, gy, gl, ok, e[W-1-:LB], e[LB:1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [LB-1:0] gx, gy; logic gl; bit ok; logic [W-1:0] e;
    int x0, y0, x1, y1;
    for (int l = 0; l < 12; l++) begin
      x0 = $urandom_range(63); y0 = $urandom_range(63);
      x1 = $urandom_range(63); y1 = $urandom_range(63);
      model_line(x0, y0, x1, y1);
      drive_line(x0, y0, x1, y1, ok);
      while (exp_q.size() > 0) begin
        collect_beat(70, gx, gy, gl, ok);
        e = exp_q.pop_front(); vectors++;
        if (!ok || {gx, gy, gl} !== e) begin
          miscompares++;
          $display("FAIL random_beat line%0d: got (%0d,%0d) last=%0b seen=%0b, want (%0d,%0d) last=%0b",
                   l, gx, gy, gl, ok, e[W-1-:LB], e[LB:1], e[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_diagonal_ignore_valid();
    test_steep_reversed();
    test_point_and_full_width();
    test_backpressure();
    test_reset_midline();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
